fcl_neuron_acc: RTL and testbench

//  Sequential accumulator directly downstream of the 2-input parallel adder in fcl_layer1.
//  It sums NUM_TERMS registered partial sums for one FC neuron and adds the neuron bias.
//  It then rescales, saturates and hands one neuron result per frame to the activation/output buffer.

---
 rtl/fcl_pkg.sv | 10 +
 rtl/fcl_sat_shift.sv | 41 ++++
 rtl/fcl_neuron_acc.sv | 135 +++++++++++++
 tb/tb_fcl_neuron_acc.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fcl_pkg.sv
// Shared state encoding and default datapath widths for the FC neuron accumulator.
package fcl_pkg;

   typedef enum logic [1:0] {FCL_IDLE, FCL_ACCUM, FCL_OUTPUT} fcl_acc_state_t;

   localparam int unsigned FCL_PSUM_WIDTH = 19;
   localparam int unsigned FCL_ACC_WIDTH  = 32;
   localparam int unsigned FCL_OUT_WIDTH  = 16;

endpackage

// File: rtl/fcl_sat_shift.sv
// Combinational rescale (arithmetic right shift), signed saturation and optional ReLU.
// Define FCL_ACC_RELU_EN to zero negative results (sat then flags positive clamping only).
module fcl_sat_shift #(
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned OUT_WIDTH  = 16,
   parameter int unsigned FRAC_SHIFT = 8
) (
   input  logic signed [ACC_WIDTH-1:0] sum,
   output logic signed [OUT_WIDTH-1:0] data,
   output logic                        sat
);

   localparam logic signed [ACC_WIDTH-1:0] MAX_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] MIN_VAL =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic signed [ACC_WIDTH-1:0] shifted;

   always_comb begin
      shifted = sum >>> FRAC_SHIFT;
      data    = shifted[OUT_WIDTH-1:0];
      sat     = 1'b0;
      if (shifted > MAX_VAL) begin
         data = MAX_VAL[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end else if (shifted < MIN_VAL) begin
         data = MIN_VAL[OUT_WIDTH-1:0];
         sat  = 1'b1;
      end
`ifdef FCL_ACC_RELU_EN
      // A negative clamp collapses to zero and is not reported as saturation.
      if (data[OUT_WIDTH-1]) begin
         data = '0;
         sat  = 1'b0;
      end
`else
`endif
   end

endmodule

// File: rtl/fcl_neuron_acc.sv
// Sequential FC-neuron accumulator: bias + NUM_TERMS partial sums, rescaled and saturated.
// Optional FCL_ACC_RELU_EN enables ReLU in the output stage (see fcl_sat_shift).
module fcl_neuron_acc
   import fcl_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = FCL_PSUM_WIDTH,
   parameter int unsigned ACC_WIDTH  = FCL_ACC_WIDTH,
   parameter int unsigned OUT_WIDTH  = FCL_OUT_WIDTH,
   parameter int unsigned NUM_TERMS  = 50,
   parameter int unsigned FRAC_SHIFT = 8
) (
   input  logic                 fcl_acc_clk,
   input  logic                 fcl_acc_rst_b,
   input  logic                 fcl_acc_clr_i,
   input  logic                 fcl_acc_in_valid_i,
   input  logic [IN_WIDTH-1:0]  fcl_acc_in_data_i,
   output logic                 fcl_acc_in_ready_o,
   input  logic [IN_WIDTH-1:0]  fcl_acc_bias_i,
   output logic                 fcl_acc_out_valid_o,
   output logic [OUT_WIDTH-1:0] fcl_acc_out_data_o,
   output logic                 fcl_acc_out_sat_o,
   input  logic                 fcl_acc_out_ready_i
);

   localparam int unsigned CNT_WIDTH = $clog2(NUM_TERMS + 1);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_TERMS - 1);

   if (ACC_WIDTH < IN_WIDTH + $clog2(NUM_TERMS + 1) || NUM_TERMS < 2) begin : g_param_check
      $error("fcl_neuron_acc: ACC_WIDTH too narrow or NUM_TERMS < 2");
   end

   fcl_acc_state_t              state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
   logic                        out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
   logic                        out_sat_q, out_sat_d;
   logic                        ready_q, ready_d;

   logic signed [ACC_WIDTH-1:0] data_ext, bias_ext, final_sum;
   logic signed [OUT_WIDTH-1:0] sat_data;
   logic                        sat_flag;
   logic                        beat;

   assign data_ext  = {{(ACC_WIDTH-IN_WIDTH){fcl_acc_in_data_i[IN_WIDTH-1]}}, fcl_acc_in_data_i};
   assign bias_ext  = {{(ACC_WIDTH-IN_WIDTH){fcl_acc_bias_i[IN_WIDTH-1]}}, fcl_acc_bias_i};
   assign final_sum = acc_q + data_ext;
   // ready_q is held low through reset and tracks "not in OUTPUT" afterwards.
   assign beat      = fcl_acc_in_valid_i & ready_q;

   fcl_sat_shift #(
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH),
      .FRAC_SHIFT (FRAC_SHIFT)
   ) u_sat_shift (
      .sum  (final_sum),
      .data (sat_data),
      .sat  (sat_flag)
   );

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      if (fcl_acc_clr_i) begin
         state_d     = FCL_IDLE;
         acc_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         out_data_d  = '0;
         out_sat_d   = 1'b0;
      end else begin
         unique case (state_q)
            FCL_IDLE: begin
               if (beat) begin
                  acc_d   = bias_ext + data_ext;
                  cnt_d   = CNT_WIDTH'(1);
                  state_d = FCL_ACCUM;
               end
            end
            FCL_ACCUM: begin
               if (beat) begin
                  acc_d = final_sum;
                  cnt_d = cnt_q + CNT_WIDTH'(1);
                  if (cnt_q == LAST_CNT) begin
                     out_valid_d = 1'b1;
                     out_data_d  = sat_data;
                     out_sat_d   = sat_flag;
                     state_d     = FCL_OUTPUT;
                  end
               end
            end
            FCL_OUTPUT: begin
               if (fcl_acc_out_ready_i) begin
                  out_valid_d = 1'b0;
                  acc_d       = '0;
                  cnt_d       = '0;
                  state_d     = FCL_IDLE;
               end
            end
            default: state_d = FCL_IDLE;
         endcase
      end
      ready_d = (state_d != FCL_OUTPUT);
   end

   always_ff @(posedge fcl_acc_clk or negedge fcl_acc_rst_b) begin
      if (!fcl_acc_rst_b) begin
         state_q     <= FCL_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         ready_q     <= ready_d;
      end
   end

   assign fcl_acc_in_ready_o  = ready_q;
   assign fcl_acc_out_valid_o = out_valid_q;
   assign fcl_acc_out_data_o  = out_data_q;
   assign fcl_acc_out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_fcl_neuron_acc.sv
// Directed self-checking bench for fcl_neuron_acc with an arithmetic reference model.
module tb_fcl_neuron_acc;

   localparam int IN_W  = 19;
   localparam int OUT_W = 16;
   localparam int NT    = 50;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr;
   logic              in_valid;
   logic [IN_W-1:0]   in_data;
   logic              in_ready;
   logic [IN_W-1:0]   bias;
   logic              out_valid;
   logic [OUT_W-1:0]  out_data;
   logic              out_sat;
   logic              out_ready;

   typedef struct {int d; bit s;} exp_t;
   exp_t exp_q[$];
   int   got_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   fcl_neuron_acc u_dut (
      .fcl_acc_clk         (clk),
      .fcl_acc_rst_b       (rst_n),
      .fcl_acc_clr_i       (clr),
      .fcl_acc_in_valid_i  (in_valid),
      .fcl_acc_in_data_i   (in_data),
      .fcl_acc_in_ready_o  (in_ready),
      .fcl_acc_bias_i      (bias),
      .fcl_acc_out_valid_o (out_valid),
      .fcl_acc_out_data_o  (out_data),
      .fcl_acc_out_sat_o   (out_sat),
      .fcl_acc_out_ready_i (out_ready)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Reference: whole-frame sum, floor shift by 8, clamp to 16-bit signed, optional ReLU.
   function automatic void model(input longint b, input longint v, input int n,
                                 output int d, output bit s);
      longint sum, sh;
      sum = b + v * n;
      sh  = sum >>> 8;
      s   = 1'b0;
      if (sh > 32767) begin
         sh = 32767;
         s  = 1'b1;
      end else if (sh < -32768) begin
         sh = -32768;
         s  = 1'b1;
      end
`ifdef FCL_ACC_RELU_EN
      if (sh < 0) begin
         sh = 0;
         s  = 1'b0;
      end
`endif
      d = int'(sh);
   endfunction

   // Output monitor: every cycle out_valid is high the result must match the model.
   initial begin
      bit              prev_valid = 1'b0;
      bit              prev_ready = 1'b0;
      logic [OUT_W-1:0] prev_data = '0;
      bit              prev_sat = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            check("in_ready_low_while_output", in_ready, 0);
            if (prev_valid && !prev_ready) begin
               check("out_data_stable", out_data, prev_data);
               check("out_sat_stable", out_sat, prev_sat);
            end
            if (exp_q.size() == 0) begin
               check("spurious_out_valid", out_valid, 0);
            end else begin
               check("out_data", int'($signed(out_data)), exp_q[0].d);
               check("out_sat", out_sat, exp_q[0].s);
               if (out_ready) begin
                  got_q.push_back(int'($signed(out_data)));
                  void'(exp_q.pop_front());
               end
            end
         end
         prev_valid = rst_n && out_valid;
         prev_ready = out_ready;
         prev_data  = out_data;
         prev_sat   = out_sat;
      end
   end

   task automatic send_frame(input int b, input int v, input int n, input bit toggle,
                             input bit push, output int first_c, output int last_c);
      int sent = 0;
      int guard = 0;
      bit phase = 1'b1;
      bit rdy;
      exp_t e;
      first_c = -1;
      last_c  = -1;
      while (sent < n && guard < 2000) begin
         in_valid = toggle ? phase : 1'b1;
         in_data  = IN_W'(v);
         bias     = IN_W'(b);
         rdy      = in_ready;
         @(posedge clk);
         #1;
         if (in_valid && rdy) begin
            sent++;
            if (sent == 1) first_c = cyc;
            last_c = cyc;
         end
         phase = ~phase;
         guard++;
      end
      in_valid = 1'b0;
      if (sent != n) check("frame_timeout", sent, n);
      if (push) begin
         model(b, v, n, e.d, e.s);
         exp_q.push_back(e);
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 300) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("drain_results", exp_q.size(), 0);
   endtask

   initial begin
      int d, f1, l1, f2, l2;
      bit s;
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; bias = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", in_ready, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_data", out_data, 0);
      check("reset_out_sat", out_sat, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("idle_in_ready", in_ready, 1);

      // Hand-computed pins on the reference model.
      model(256, 256, NT, d, s);
      check("model_t1_data", d, 51);
      check("model_t1_sat", s, 0);
      model(0, 262143, NT, d, s);
      check("model_t2_data", d, 32767);
      check("model_t2_sat", s, 1);
      model(0, -262144, NT, d, s);
`ifdef FCL_ACC_RELU_EN
      check("model_t3_data", d, 0);
      check("model_t3_sat", s, 0);
`else
      check("model_t3_data", d, -32768);
      check("model_t3_sat", s, 1);
`endif
      model(-100, 2, NT, d, s);
      check("model_t5_data", d, 0);

      // 1 and 2: back-to-back frames, positive saturation in the second.
      send_frame(256, 256, NT, 1'b0, 1'b1, f1, l1);
      check("t1_valid_after_last_beat", out_valid, 1);
      send_frame(0, 262143, NT, 1'b0, 1'b1, f2, l2);
      check("t1_next_frame_start", f2 - f1, 51);
      drain();
      check("t1_result_literal", got_q[0], 51);
      check("t2_result_literal", got_q[1], 32767);

      // 3: negative saturation.
      send_frame(0, -262144, NT, 1'b0, 1'b1, f1, l1);
      drain();

      // 4: consumer stall for 5 cycles.
      out_ready = 1'b0;
      send_frame(256, 256, NT, 1'b0, 1'b1, f1, l1);
      for (int i = 0; i < 5; i++) begin
         check("t4_stalled_valid", out_valid, 1);
         check("t4_stalled_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("t4_after_handoff_valid", out_valid, 0);
      check("t4_after_handoff_in_ready", in_ready, 1);
      check("t4_queue_empty", exp_q.size(), 0);

      // 5: alternating bubbles.
      send_frame(-100, 2, NT, 1'b1, 1'b1, f1, l1);
      check("t5_span", l1 - f1, 98);
      check("t5_valid_after_last_beat", out_valid, 1);
      drain();
      check("t5_result_literal", got_q[got_q.size()-1], 0);

      // 6a: synchronous clear mid-frame, beat in the clear cycle ignored.
      send_frame(1000, 5000, 20, 1'b0, 1'b0, f1, l1);
      clr = 1'b1; in_valid = 1'b1; in_data = IN_W'(777);
      @(posedge clk);
      #1;
      clr = 1'b0; in_valid = 1'b0;
      check("t6_clr_out_valid", out_valid, 0);
      check("t6_clr_in_ready", in_ready, 1);
      send_frame(512, 256, NT, 1'b0, 1'b1, f1, l1);
      drain();
      check("t6_clr_result_literal", got_q[got_q.size()-1], 52);

      // 6b: asynchronous reset mid-frame.
      send_frame(1000, 5000, 30, 1'b0, 1'b0, f1, l1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_out_valid", out_valid, 0);
      check("t6_rst_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_frame(-256, 256, NT, 1'b0, 1'b1, f1, l1);
      drain();
      check("t6_rst_result_literal", got_q[got_q.size()-1], 49);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
